// File: rtl/t_bird.sv
// t_bird: Thunderbird-style tail-light sequencer.
// Three active-low buttons (left, right, hazard) are synchronized and drive a
// stepped chase on three LEDs per side, or an all-LED hazard flash. The state
// machine advances only on a divided step tick, and the LED flops are loaded
// from the decode of the next state so lamps change on the same edge as state.
module t_bird #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic right_button,
  input  logic left_button,
  input  logic hazard_button,
  output logic right_led1,
  output logic right_led2,
  output logic right_led3,
  output logic left_led1,
  output logic left_led2,
  output logic left_led3
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_HAZ  = 3'd7
  } state_t;

  // Two-stage synchronizers; bit 1 is the settled, metastability-free stage.
  logic [1:0]       left_sync_q;
  logic [1:0]       right_sync_q;
  logic [1:0]       hazard_sync_q;

  logic             req_l_s;
  logic             req_r_s;
  logic             req_h_s;

  logic [CNT_W-1:0] step_cnt_q;
  logic [CNT_W-1:0] step_cnt_d;
  logic             tick_s;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       left_led_q;
  logic [2:0]       left_led_d;
  logic [2:0]       right_led_q;
  logic [2:0]       right_led_d;

  // Button synchronizers; reset value is "released" so no phantom request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      left_sync_q   <= 2'b11;
      right_sync_q  <= 2'b11;
      hazard_sync_q <= 2'b11;
    end else begin
      left_sync_q   <= {left_sync_q[0], left_button};
      right_sync_q  <= {right_sync_q[0], right_button};
      hazard_sync_q <= {hazard_sync_q[0], hazard_button};
    end
  end

  // Buttons are active-low; requests are active-high.
  assign req_l_s = ~left_sync_q[1];
  assign req_r_s = ~right_sync_q[1];
  assign req_h_s = ~hazard_sync_q[1];

  // Step tick fires on the last count, so the first tick is STEP_CYCLES after reset.
  always_comb begin
    tick_s     = (step_cnt_q == CNT_LAST);
    step_cnt_d = step_cnt_q + CNT_W'(1);
    if (tick_s) begin
      step_cnt_d = {CNT_W{1'b0}};
    end else begin
      step_cnt_d = step_cnt_q + CNT_W'(1);
    end
  end

  // Free-running step counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_cnt_q <= {CNT_W{1'b0}};
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  // Next-state logic; hazard wins over any chase, opposite direction waits for IDLE.
  always_comb begin
    state_d = state_q;
    if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (req_h_s || (req_l_s && req_r_s)) begin
            state_d = ST_HAZ;
          end else if (req_l_s) begin
            state_d = ST_L1;
          end else if (req_r_s) begin
            state_d = ST_R1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_L1:   state_d = req_h_s ? ST_HAZ : ST_L2;
        ST_L2:   state_d = req_h_s ? ST_HAZ : ST_L3;
        ST_L3:   state_d = req_h_s ? ST_HAZ : ST_IDLE;
        ST_R1:   state_d = req_h_s ? ST_HAZ : ST_R2;
        ST_R2:   state_d = req_h_s ? ST_HAZ : ST_R3;
        ST_R3:   state_d = req_h_s ? ST_HAZ : ST_IDLE;
        ST_HAZ:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // LED pattern for the state being entered, so lamps track the state register.
  always_comb begin
    left_led_d  = 3'b000;
    right_led_d = 3'b000;
    case (state_d)
      ST_L1:  left_led_d  = 3'b001;
      ST_L2:  left_led_d  = 3'b011;
      ST_L3:  left_led_d  = 3'b111;
      ST_R1:  right_led_d = 3'b001;
      ST_R2:  right_led_d = 3'b011;
      ST_R3:  right_led_d = 3'b111;
      ST_HAZ: begin
        left_led_d  = 3'b111;
        right_led_d = 3'b111;
      end
      default: begin
        left_led_d  = 3'b000;
        right_led_d = 3'b000;
      end
    endcase
  end

  // Sequencer state and registered lamp outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      left_led_q  <= 3'b000;
      right_led_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      left_led_q  <= left_led_d;
      right_led_q <= right_led_d;
    end
  end

  assign left_led1  = left_led_q[0];
  assign left_led2  = left_led_q[1];
  assign left_led3  = left_led_q[2];
  assign right_led1 = right_led_q[0];
  assign right_led2 = right_led_q[1];
  assign right_led3 = right_led_q[2];

endmodule

// File: tb/tb_t_bird.sv
// Testbench for t_bird: a behavioural reference model pushes the expected LED
// vector every clock; a sampler on the falling edge pops and compares it.
// Directed checks cover the reset, hazard-from-R2 and restart-after-reset cases.
module tb_t_bird;

  localparam int STEP = 4;

  logic clock         = 1'b0;
  logic reset         = 1'b0;
  logic right_button  = 1'b1;
  logic left_button   = 1'b1;
  logic hazard_button = 1'b1;
  logic right_led1, right_led2, right_led3;
  logic left_led1, left_led2, left_led3;
  logic [5:0] leds_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {left3,left2,left1,right3,right2,right1}, one entry per clock.
  logic [5:0] exp_q[$];

  // Reference model state: 0 idle, 1..3 left steps, 4..6 right steps, 7 hazard.
  logic [1:0] m_ls = 2'b11;
  logic [1:0] m_rs = 2'b11;
  logic [1:0] m_hs = 2'b11;
  int m_cnt = 0;
  int m_st  = 0;

  t_bird #(.STEP_CYCLES(STEP)) dut (
    .clock         (clock),
    .reset         (reset),
    .right_button  (right_button),
    .left_button   (left_button),
    .hazard_button (hazard_button),
    .right_led1    (right_led1),
    .right_led2    (right_led2),
    .right_led3    (right_led3),
    .left_led1     (left_led1),
    .left_led2     (left_led2),
    .left_led3     (left_led3)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  assign leds_s = {left_led3, left_led2, left_led1, right_led3, right_led2, right_led1};

  function automatic int next_code(input int st, input bit l, input bit r, input bit h);
    case (st)
      0:       return (h || (l && r)) ? 7 : (l ? 1 : (r ? 4 : 0));
      1, 2:    return h ? 7 : st + 1;
      3:       return h ? 7 : 0;
      4, 5:    return h ? 7 : st + 1;
      6:       return h ? 7 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [5:0] leds_of(input int st);
    case (st)
      1:       return 6'b001_000;
      2:       return 6'b011_000;
      3:       return 6'b111_000;
      4:       return 6'b000_001;
      5:       return 6'b000_011;
      6:       return 6'b000_111;
      7:       return 6'b111_111;
      default: return 6'b000_000;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model; asynchronous reset discards any pending expectation.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ls  <= 2'b11;
      m_rs  <= 2'b11;
      m_hs  <= 2'b11;
      m_cnt <= 0;
      m_st  <= 0;
      exp_q.delete();
      exp_q.push_back(6'b000_000);
    end else begin
      m_ls <= {m_ls[0], left_button};
      m_rs <= {m_rs[0], right_button};
      m_hs <= {m_hs[0], hazard_button};
      if (m_cnt == STEP - 1) begin
        m_cnt <= 0;
        m_st  <= next_code(m_st, !m_ls[1], !m_rs[1], !m_hs[1]);
        exp_q.push_back(leds_of(next_code(m_st, !m_ls[1], !m_rs[1], !m_hs[1])));
      end else begin
        m_cnt <= m_cnt + 1;
        exp_q.push_back(leds_of(m_st));
      end
    end
  end

  // Scoreboard sampler, away from the active edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      check_eq("leds", leds_s, exp_q.pop_front());
    end
  end

  initial begin
    int guard;
    logic [5:0] reached;

    // Reset and idle.
    repeat (5) @(negedge clock);
    check_eq("in_reset", leds_s, 6'b000_000);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_eq("idle_after_reset", leds_s, 6'b000_000);

    // Right turn held 1000 ns, then released.
    right_button = 1'b0;
    repeat (100) @(negedge clock);
    right_button = 1'b1;
    repeat (40) @(negedge clock);
    check_eq("right_done_idle", leds_s, 6'b000_000);

    // Left turn, same stimulus.
    left_button = 1'b0;
    repeat (100) @(negedge clock);
    left_button = 1'b1;
    repeat (40) @(negedge clock);
    check_eq("left_done_idle", leds_s, 6'b000_000);

    // Hazard held.
    hazard_button = 1'b0;
    repeat (40) @(negedge clock);
    hazard_button = 1'b1;
    repeat (20) @(negedge clock);
    check_eq("hazard_done_idle", leds_s, 6'b000_000);

    // Hazard pressed right as R2 begins: next tick goes all-on.
    right_button = 1'b0;
    guard = 0;
    while (m_st != 5 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    reached = (m_st == 5) ? 6'd1 : 6'd0;
    check_eq("r2_reached", reached, 6'd1);
    check_eq("in_r2", leds_s, 6'b000_011);
    right_button  = 1'b1;
    hazard_button = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("haz_from_r2", leds_s, 6'b111_111);
    repeat (12) @(negedge clock);
    hazard_button = 1'b1;
    repeat (20) @(negedge clock);

    // Left and right together from IDLE behave as hazard.
    left_button  = 1'b0;
    right_button = 1'b0;
    guard = 0;
    while (m_st != 7 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check_eq("both_as_hazard", leds_s, 6'b111_111);
    repeat (16) @(negedge clock);
    left_button  = 1'b1;
    right_button = 1'b1;
    repeat (20) @(negedge clock);

    // Reset mid-operation, then restart with right still held.
    right_button = 1'b0;
    repeat (50) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_reset", leds_s, 6'b000_000);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      case (n)
        3:       check_eq("restart_wait", leds_s, 6'b000_000);
        5:       check_eq("restart_r1", leds_s, 6'b000_001);
        9:       check_eq("restart_r2", leds_s, 6'b000_011);
        13:      check_eq("restart_r3", leds_s, 6'b000_111);
        17:      check_eq("restart_idle", leds_s, 6'b000_000);
        default: ;
      endcase
    end
    right_button = 1'b1;
    repeat (30) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
